// File: rtl/svfloat_pkg.sv
// Shared floating-point types for the svfloat arithmetic blocks.
// IEEE-754 binary32 layout plus the field widths the datapaths derive from it.
package svfloat;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } float32;

endpackage

// File: rtl/svfloat_mul.sv
// Pipelined binary32 multiplier with round-to-nearest-even; subnormals flush to zero.
// Optional operand and result register stages; pipeline registers carry no reset.
module svfloat_mul
    import svfloat::*;
#(
    parameter type         float        = float32,
    parameter int unsigned plr_pre_mul  = 0,
    parameter int unsigned plr_post_mul = 0
) (
    input  logic clk,
    input  float i_lhs,
    input  float i_rhs,
    output float o_res
);

    localparam int unsigned SIG_W   = MAN_W + 1;
    localparam int unsigned P_W     = 2 * SIG_W;
    localparam int unsigned E_W     = EXP_W + 2;
    localparam int          EXP_INF = (1 << EXP_W) - 1;

    float              w_a;
    float              w_b;
    float32            w_fa;
    float32            w_fb;
    float32            w_core;
    logic [P_W-1:0]    w_prod;
    logic [MAN_W-1:0]  w_man;
    logic [SIG_W-1:0]  w_man_rnd;
    logic              w_guard;
    logic              w_sticky;
    logic signed [E_W-1:0] w_exp;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic              w_unused_clk;

    // clk is idle when both stage counts are zero
    assign w_unused_clk = clk;

    generate
        if (plr_pre_mul == 0) begin : g_pre_none
            assign w_a = i_lhs;
            assign w_b = i_rhs;
        end else begin : g_pre
            float r_a [plr_pre_mul];
            float r_b [plr_pre_mul];
            always_ff @(posedge clk) begin
                r_a[0] <= i_lhs;
                r_b[0] <= i_rhs;
                for (int unsigned s = 1; s < plr_pre_mul; s++) begin
                    r_a[s] <= r_a[s-1];
                    r_b[s] <= r_b[s-1];
                end
            end
            assign w_a = r_a[plr_pre_mul-1];
            assign w_b = r_b[plr_pre_mul-1];
        end
    endgenerate

    assign w_fa = w_a;
    assign w_fb = w_b;

    assign w_a_zero = (w_fa.exp == '0);
    assign w_b_zero = (w_fb.exp == '0);
    assign w_a_inf  = (w_fa.exp == '1) && (w_fa.man == '0);
    assign w_b_inf  = (w_fb.exp == '1) && (w_fb.man == '0);
    assign w_a_nan  = (w_fa.exp == '1) && (w_fa.man != '0);
    assign w_b_nan  = (w_fb.exp == '1) && (w_fb.man != '0);

    always_comb begin
        w_prod   = P_W'({1'b1, w_fa.man}) * P_W'({1'b1, w_fb.man});
        w_exp    = E_W'(w_fa.exp) + E_W'(w_fb.exp) - E_W'(BIAS);
        w_man    = w_prod[P_W-3 -: MAN_W];
        w_guard  = w_prod[P_W-3-MAN_W];
        w_sticky = |w_prod[P_W-4-MAN_W:0];
        // significand product in [2,4) needs one more shift
        if (w_prod[P_W-1]) begin
            w_man    = w_prod[P_W-2 -: MAN_W];
            w_guard  = w_prod[P_W-2-MAN_W];
            w_sticky = |w_prod[P_W-3-MAN_W:0];
            w_exp    = w_exp + E_W'(1);
        end
        w_man_rnd = {1'b0, w_man} + SIG_W'(w_guard & (w_sticky | w_man[0]));
        if (w_man_rnd[MAN_W]) begin
            w_exp = w_exp + E_W'(1);
        end
        w_core.sign = w_fa.sign ^ w_fb.sign;
        w_core.exp  = w_exp[EXP_W-1:0];
        w_core.man  = w_man_rnd[MAN_W-1:0];
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_core.sign = 1'b0;
            w_core.exp  = '1;
            w_core.man  = {1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_a_inf || w_b_inf || (int'(w_exp) >= EXP_INF)) begin
            w_core.exp = '1;
            w_core.man = '0;
        end else if (w_a_zero || w_b_zero || (int'(w_exp) <= 0)) begin
            w_core.exp = '0;
            w_core.man = '0;
        end
    end

    generate
        if (plr_post_mul == 0) begin : g_post_none
            assign o_res = w_core;
        end else begin : g_post
            float r_res [plr_post_mul];
            always_ff @(posedge clk) begin
                r_res[0] <= w_core;
                for (int unsigned s = 1; s < plr_post_mul; s++) begin
                    r_res[s] <= r_res[s-1];
                end
            end
            assign o_res = r_res[plr_post_mul-1];
        end
    endgenerate

endmodule

// File: rtl/svfloat_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among n_req requesters.
// A valid/index tag travels alongside the multiplier so each product is steered back.
module svfloat_mul_arbiter
    import svfloat::*;
#(
    parameter type         float        = float32,
    parameter int unsigned n_req        = 4,
    parameter int unsigned plr_pre_mul  = 0,
    parameter int unsigned plr_post_mul = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [n_req-1:0] req_valid,
    output logic [n_req-1:0] req_ready,
    input  float             req_lhs [n_req],
    input  float             req_rhs [n_req],
    output logic [n_req-1:0] resp_valid,
    output float             resp_res
);

    localparam int unsigned L     = plr_pre_mul + plr_post_mul;
    localparam int unsigned IDX_W = (n_req > 1) ? $clog2(n_req) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic             w_gnt;
    logic [IDX_W-1:0] w_gnt_idx;
    int unsigned      w_cand;
    logic             w_tag_v;
    logic [IDX_W-1:0] w_tag_idx;
    float             w_lhs;
    float             w_rhs;

    // first valid requester at or after the pointer, wrapping
    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        w_cand    = 0;
        for (int unsigned k = 0; k < n_req; k++) begin
            w_cand = 32'(r_ptr) + k;
            if (w_cand >= n_req) begin
                w_cand = w_cand - n_req;
            end
            if (!w_gnt && !rst && req_valid[IDX_W'(w_cand)]) begin
                w_gnt     = 1'b1;
                w_gnt_idx = IDX_W'(w_cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_gnt) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_gnt) begin
            r_ptr <= (32'(w_gnt_idx) + 32'd1 >= n_req) ? '0 : w_gnt_idx + IDX_W'(1);
        end
    end

    assign w_lhs = req_lhs[w_gnt_idx];
    assign w_rhs = req_rhs[w_gnt_idx];

    generate
        if (L == 0) begin : g_tag_none
            assign w_tag_v   = w_gnt;
            assign w_tag_idx = w_gnt_idx;
        end else begin : g_tag
            logic [L-1:0]     r_tag_v;
            logic [IDX_W-1:0] r_tag_idx [L];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag_v <= '0;
                end else begin
                    r_tag_v <= (r_tag_v << 1) | L'(w_gnt);
                end
                r_tag_idx[0] <= w_gnt_idx;
                for (int unsigned s = 1; s < L; s++) begin
                    r_tag_idx[s] <= r_tag_idx[s-1];
                end
            end
            assign w_tag_v   = r_tag_v[L-1];
            assign w_tag_idx = r_tag_idx[L-1];
        end
    endgenerate

    // reset masks the response even on the zero-latency path
    always_comb begin
        resp_valid = '0;
        if (w_tag_v && !rst) begin
            resp_valid[w_tag_idx] = 1'b1;
        end
    end

    svfloat_mul #(
        .float        (float),
        .plr_pre_mul  (plr_pre_mul),
        .plr_post_mul (plr_post_mul)
    ) u_mul (
        .clk   (clk),
        .i_lhs (w_lhs),
        .i_rhs (w_rhs),
        .o_res (resp_res)
    );

endmodule

// File: tb/tb_svfloat_mul_arbiter.sv
// Bench for svfloat_mul_arbiter: a latency-2 and a latency-0 instance share stimulus
// and are checked every cycle against a queue-based model, plus literal expectations.
module tb_svfloat_mul_arbiter;
    import svfloat::*;

    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    float32        req_lhs [NR];
    float32        req_rhs [NR];
    logic [NR-1:0] rdy_a, rv_a, rdy_b, rv_b;
    float32        res_a, res_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    typedef struct {
        int          u;
        int          due;
        int          idx;
        logic [31:0] prod;
    } resp_t;

    resp_t m_q [$];
    int    m_ptr [2];
    logic [NR-1:0] seq [6];

    svfloat_mul_arbiter #(.n_req(NR), .plr_pre_mul(1), .plr_post_mul(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a),
        .req_lhs(req_lhs), .req_rhs(req_rhs), .resp_valid(rv_a), .resp_res(res_a)
    );

    svfloat_mul_arbiter #(.n_req(NR), .plr_pre_mul(0), .plr_post_mul(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b),
        .req_lhs(req_lhs), .req_rhs(req_rhs), .resp_valid(rv_b), .resp_res(res_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // binary32 normal -> double (exact), multiply in real, round the double back to binary32
    function automatic real to_real(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        real         p;
        logic [63:0] d;
        logic [22:0] m;
        int          e;
        p = to_real(a) * to_real(b);
        d = $realtobits(p);
        e = int'(d[62:52]) - 896;
        m = d[51:29];
        if (d[28] && ((|d[27:0]) || m[0])) begin
            if (&m) begin
                m = '0;
                e++;
            end else begin
                m = m + 23'd1;
            end
        end
        return {d[63], 8'(e), m};
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    task automatic check_unit(input int u, input int lat, input logic [NR-1:0] rdy,
                              input logic [NR-1:0] rv, input logic [31:0] res);
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rv;
        logic [31:0]   exp_res;
        int            win;
        resp_t         keep [$];
        exp_rdy = '0;
        exp_rv  = '0;
        exp_res = '0;
        win     = -1;
        if (!rst) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_ptr[u] + k) % NR;
                if (win < 0 && req_valid[c]) win = c;
            end
        end
        if (win >= 0) begin
            exp_rdy[win] = 1'b1;
            m_q.push_back('{u, cyc + lat, win, fmul_ref(req_lhs[win], req_rhs[win])});
            m_ptr[u] = (win + 1) % NR;
        end
        foreach (m_q[i]) begin
            if (m_q[i].u == u && m_q[i].due == cyc && !rst) begin
                exp_rv[m_q[i].idx] = 1'b1;
                exp_res = m_q[i].prod;
            end
        end
        foreach (m_q[i]) begin
            if (!(m_q[i].u == u && (rst || m_q[i].due <= cyc))) keep.push_back(m_q[i]);
        end
        m_q = keep;
        if (rst) m_ptr[u] = 0;
        chk((u == 0) ? "model_ready_L2" : "model_ready_L0", 32'(rdy), 32'(exp_rdy));
        chk((u == 0) ? "model_resp_valid_L2" : "model_resp_valid_L0", 32'(rv), 32'(exp_rv));
        if (exp_rv != '0) chk((u == 0) ? "model_resp_res_L2" : "model_resp_res_L0", res, exp_res);
    endtask

    always @(negedge clk) begin
        if (!done) begin
            cyc++;
            check_unit(0, 2, rdy_a, rv_a, res_a);
            check_unit(1, 0, rdy_b, rv_b, res_b);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            req_lhs[i] = rnd_f();
            req_rhs[i] = rnd_f();
        end
    endtask

    initial begin
        m_ptr[0] = 0;
        m_ptr[1] = 0;
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
        seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
        rst = 1'b1;
        req_valid = '0;
        rand_ops();
        next_cycle();
        #3;
        chk("reset_ready", 32'(rdy_a), 32'd0);
        chk("reset_resp_L0", 32'(rv_b), 32'd0);
        next_cycle();
        rst = 1'b0;

        // all requesters valid straight out of reset
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #3;
            chk("rr_grant_L2", 32'(rdy_a), 32'(seq[k]));
            chk("rr_grant_L0", 32'(rdy_b), 32'(seq[k]));
            if (k >= 2) chk("rr_resp_L2", 32'(rv_a), 32'(seq[k-2]));
            next_cycle();
            rand_ops();
        end
        req_valid = '0;
        repeat (3) next_cycle();

        // single requester 1: 1.5 * 2.0
        req_lhs[1] = 32'h3FC00000;
        req_rhs[1] = 32'h40000000;
        req_valid  = 3'b010;
        #3;
        chk("single_ready_L2", 32'(rdy_a), 32'h2);
        chk("single_resp_L0", 32'(rv_b), 32'h2);
        chk("single_res_L0", res_b, 32'h40400000);
        next_cycle();
        req_valid = '0;
        next_cycle();
        #3;
        chk("single_resp_L2", 32'(rv_a), 32'h2);
        chk("single_res_L2", res_a, 32'h40400000);
        next_cycle();

        // requester 0: -2.0 * 0.5 with same-cycle response at L=0
        req_lhs[0] = 32'hC0000000;
        req_rhs[0] = 32'h3F000000;
        req_valid  = 3'b001;
        #3;
        chk("l0_ready", 32'(rdy_b), 32'h1);
        chk("l0_resp", 32'(rv_b), 32'h1);
        chk("l0_res", res_b, 32'hBF800000);
        next_cycle();
        req_valid = '0;
        repeat (2) next_cycle();

        // rounding: sticky below guard, then an exact tie to even
        req_lhs[2] = 32'h3F800001;
        req_rhs[2] = 32'h3F800001;
        req_valid  = 3'b100;
        #3;
        chk("round_sticky_res", res_b, 32'h3F800002);
        next_cycle();
        req_lhs[1] = 32'h3F800800;
        req_rhs[1] = 32'h3F800800;
        req_valid  = 3'b010;
        #3;
        chk("round_tie_res", res_b, 32'h3F801000);
        next_cycle();
        req_valid = '0;
        repeat (2) next_cycle();

        // pointer wrap: 2 alone, then 0 and 2 together
        rand_ops();
        req_valid = 3'b100;
        #3;
        chk("wrap_grant0", 32'(rdy_a), 32'h4);
        next_cycle();
        req_valid = 3'b101;
        #3;
        chk("wrap_grant1", 32'(rdy_a), 32'h1);
        next_cycle();
        #3;
        chk("wrap_grant2", 32'(rdy_a), 32'h4);
        next_cycle();
        req_valid = '0;
        repeat (2) next_cycle();

        // reset with two operations in flight
        req_valid = 3'b011;
        repeat (2) next_cycle();
        rst = 1'b1;
        req_valid = 3'b111;
        #3;
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_resp_L2", 32'(rv_a), 32'd0);
        next_cycle();
        rst = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("post_rst_resp_L2", 32'(rv_a), 32'd0);
            next_cycle();
        end
        req_valid = 3'b111;
        #3;
        chk("post_rst_grant", 32'(rdy_a), 32'h1);
        next_cycle();
        req_valid = '0;
        repeat (3) next_cycle();

        // random traffic with occasional reset
        for (int k = 0; k < 10000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            req_valid = NR'($urandom);
            rand_ops();
            next_cycle();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (4) next_cycle();
        @(negedge clk);
        #1;
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/svfloat_mul_arbiter.md
SVFLOAT_MUL_ARBITER -- requirements
Module: svfloat_mul_arbiter

Interface
REQ-001 SHALL have parameter float, default svfloat::float32: floating-point type of all operands and results.
REQ-002 SHALL have parameter n_req, default 4, legal range 1..16: number of requesters.
REQ-003 SHALL have parameter plr_pre_mul, default 0: passed to the shared multiplier unchanged.
REQ-004 SHALL have parameter plr_post_mul, default 0: passed to the shared multiplier unchanged.
REQ-005 SHALL have port clk, input, 1 bit: the only clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, n_req bits: requester i presents an operation.
REQ-008 SHALL have port req_ready, output, n_req bits: requester i accepted this cycle (one-hot or zero).
REQ-009 SHALL have port req_lhs, input, n_req x float: left operands.
REQ-010 SHALL have port req_rhs, input, n_req x float: right operands.
REQ-011 SHALL have port resp_valid, output, n_req bits: result for requester i on resp_res (one-hot or zero).
REQ-012 SHALL have port resp_res, output, float: shared product bus.

Function
REQ-013 SHALL define L = plr_pre_mul + plr_post_mul; L SHALL be 0, 1 or 2.
REQ-014 SHALL grant at most one requester per cycle; req_ready[i] SHALL be high only when req_valid[i] is high and i is granted.
REQ-015 SHALL arbitrate round-robin: search starts at pointer p, then p+1 and onward modulo n_req; the first valid requester wins.
REQ-016 SHALL set p to (winner+1) mod n_req on every grant; p SHALL hold when there is no grant.
REQ-017 SHALL grant a valid requester every cycle (no bubbles); the multiplier accepts one operation per cycle.
REQ-018 SHALL drive the granted requester's lhs/rhs into the multiplier; with no grant, operands are don't-care.
REQ-019 SHALL carry a valid bit and a requester index, of width max(1, $clog2(n_req)), through an L-stage shift register that matches the multiplier latency.
REQ-020 SHALL assert resp_valid[idx] exactly L cycles after the accepting edge (combinationally in the grant cycle when L=0), for exactly one cycle.
REQ-021 SHALL drive resp_res with the multiplier output; resp_res is meaningful only while resp_valid is nonzero.
REQ-022 SHALL NOT apply back-pressure on responses: requesters always accept resp_valid.
REQ-023 SHALL deliver results in grant order; results per requester SHALL stay in order.
REQ-024 SHALL tolerate req_valid dropping without a grant; an ungranted request SHALL NOT be remembered.
REQ-025 SHALL give a requester that is continuously valid a grant within n_req cycles.
REQ-026 SHALL make n_req=1 degenerate to req_ready = req_valid, with the pointer held at 0.

Reset
REQ-027 SHALL, while rst is high: set req_ready=0, set p=0, and clear all tag valid bits.
REQ-028 SHALL, while rst is high, force resp_valid to 0 (including when L=0).
REQ-029 SHALL drop operations in flight when reset is asserted mid-operation; no resp_valid SHALL appear for them after reset.
REQ-030 SHALL track validity only in this block; the multiplier's pipeline registers are not reset.

Structure
REQ-031 SHALL take float types from the shared svfloat package; no new package typedefs are needed.
REQ-032 SHALL instantiate exactly one sub-module, svfloat_mul, with float, plr_pre_mul and plr_post_mul forwarded and clk connected.
REQ-033 SHALL keep the tag width and L as local parameters computed inside the block.

Verification
REQ-034 SHALL cover: n_req=3, L=2, only req 1 valid with 0x3FC00000 x 0x40000000 -> req_ready[1] in cycle 0; resp_valid=3'b010 and resp_res=0x40400000 at cycle 2.
REQ-035 SHALL cover: all 3 requesters valid continuously from reset -> grants 0,1,2,0,1,2; resp_valid follows the same sequence delayed by 2 cycles.
REQ-036 SHALL cover: L=0, req 0 valid with 0xC0000000 x 0x3F000000 -> same-cycle req_ready[0]=1, resp_valid[0]=1, resp_res=0xBF800000.
REQ-037 SHALL cover: rst pulsed one cycle after two grants with L=2 -> no resp_valid for 3 cycles after reset; next grant goes to req 0.
REQ-038 SHALL cover: req 2 valid alone, then req 0 and req 2 both valid -> grant order 2, 0, 2 (pointer wrap).
REQ-039 SHALL cover: a random 10k-cycle run against a reference queue -> every accepted operation gets exactly one correct, in-order response.
